// File: rtl/sound_pkg.sv
// Shared definitions for the sound RAM arbiter: FSM state encoding and bus widths.
package sound_pkg;

    localparam int SND_ADDR_W = 16;
    localparam int SND_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sound_ram_arbiter.sv
// Two-way sound RAM arbiter: DOC sample fetches have priority, the host is
// protected from starvation after STARVE_LIMIT consecutive DOC wins.
module sound_ram_arbiter
    import sound_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  doc_req,
    input  logic [SND_ADDR_W-1:0] doc_addr,
    output logic                  doc_gnt,
    output logic [SND_DATA_W-1:0] doc_rdata,
    output logic                  doc_rvalid,
    input  logic                  host_req,
    input  logic                  host_wr,
    input  logic [SND_ADDR_W-1:0] host_addr,
    input  logic [SND_DATA_W-1:0] host_wdata,
    output logic                  host_gnt,
    output logic [SND_DATA_W-1:0] host_rdata,
    output logic                  host_rvalid,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [SND_ADDR_W-1:0] ram_addr,
    output logic [SND_DATA_W-1:0] ram_wdata,
    input  logic [SND_DATA_W-1:0] ram_rdata,
    output logic                  arb_busy
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t state;
    logic [3:0] starve_cnt;
    logic       owner_host;
    logic       acc_wr;
    logic       any_req;
    logic       host_win;
    logic       decide;

    assign any_req  = doc_req | host_req;
    assign host_win = host_req && (!doc_req || starve_cnt == LIMIT);
    assign decide   = (state == ST_IDLE) || (state == ST_WAIT);
    assign arb_busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            starve_cnt  <= '0;
            owner_host  <= 1'b0;
            acc_wr      <= 1'b0;
            doc_gnt     <= 1'b0;
            host_gnt    <= 1'b0;
            doc_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            doc_rdata   <= '0;
            host_rdata  <= '0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
        end else begin
            doc_gnt     <= 1'b0;
            host_gnt    <= 1'b0;
            doc_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;

            // Count DOC wins only while the host is actually waiting.
            if (!host_req)
                starve_cnt <= '0;
            else if (decide && any_req) begin
                if (host_win)
                    starve_cnt <= '0;
                else if (starve_cnt != LIMIT)
                    starve_cnt <= starve_cnt + 4'd1;
            end

            case (state)
                ST_IDLE, ST_WAIT: begin
                    if (state == ST_WAIT && !acc_wr) begin
                        if (owner_host) begin
                            host_rdata  <= ram_rdata;
                            host_rvalid <= 1'b1;
                        end else begin
                            doc_rdata  <= ram_rdata;
                            doc_rvalid <= 1'b1;
                        end
                    end
                    if (any_req) begin
                        state      <= ST_ACCESS;
                        owner_host <= host_win;
                        acc_wr     <= host_win && host_wr;
                        ram_en     <= 1'b1;
                        ram_we     <= host_win && host_wr;
                        ram_addr   <= host_win ? host_addr : doc_addr;
                        if (host_win)
                            ram_wdata <= host_wdata;
                        host_gnt   <= host_win;
                        doc_gnt    <= !host_win;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ACCESS: state <= ST_WAIT;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sound_ram_arbiter.sv
// Scoreboard bench for sound_ram_arbiter: expected read data is queued per
// requester at grant time and checked when the matching rvalid strobe fires.
module tb_sound_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        doc_req;
    logic [15:0] doc_addr;
    logic        doc_gnt;
    logic [7:0]  doc_rdata;
    logic        doc_rvalid;
    logic        host_req;
    logic        host_wr;
    logic [15:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_gnt;
    logic [7:0]  host_rdata;
    logic        host_rvalid;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        arb_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] mem [0:65535];
    logic [7:0] doc_q  [$];
    logic [7:0] host_q [$];

    sound_ram_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .doc_req(doc_req), .doc_addr(doc_addr), .doc_gnt(doc_gnt),
        .doc_rdata(doc_rdata), .doc_rvalid(doc_rvalid),
        .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: read data is valid the cycle after ram_en.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (doc_gnt || host_gnt) begin
                total++;
                if (doc_gnt && host_gnt) begin
                    bad++;
                    $display("FAIL onehot_gnt: doc_gnt=%b host_gnt=%b want at most one", doc_gnt, host_gnt);
                end
            end
            if (doc_rvalid) begin
                total++;
                if (doc_q.size() == 0) begin
                    bad++;
                    $display("FAIL doc_rvalid_unexpected: got data %h with nothing pending", doc_rdata);
                end else begin
                    logic [7:0] e;
                    e = doc_q.pop_front();
                    if (doc_rdata !== e) begin
                        bad++;
                        $display("FAIL doc_rdata: got %h want %h", doc_rdata, e);
                    end
                end
            end
            if (host_rvalid) begin
                total++;
                if (host_q.size() == 0) begin
                    bad++;
                    $display("FAIL host_rvalid_unexpected: got data %h with nothing pending", host_rdata);
                end else begin
                    logic [7:0] e;
                    e = host_q.pop_front();
                    if (host_rdata !== e) begin
                        bad++;
                        $display("FAIL host_rdata: got %h want %h", host_rdata, e);
                    end
                end
            end
        end
    end

    function automatic logic [46:0] all_outs();
        return {doc_gnt, host_gnt, doc_rvalid, host_rvalid, ram_en, ram_we, arb_busy,
                ram_addr, ram_wdata, doc_rdata, host_rdata};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; doc_req = 0; doc_addr = '0; host_req = 0; host_wr = 0;
        host_addr = '0; host_wdata = '0;
        repeat (2) @(negedge clk);
        total++;
        if (all_outs() !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", all_outs());
        end
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (arb_busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_busy: got %b want 0", arb_busy);
        end
    endtask

    task automatic test_doc_read();
        doc_q.push_back(8'h5A);
        doc_addr = 16'h1234; doc_req = 1'b1;
        @(negedge clk);
        total++;
        if ({doc_gnt, host_gnt, ram_en, ram_we, arb_busy, ram_addr} !== {5'b10101, 16'h1234}) begin
            bad++;
            $display("FAIL doc_access: got gnt=%b hgnt=%b en=%b we=%b busy=%b addr=%h want 1 0 1 0 1 1234",
                     doc_gnt, host_gnt, ram_en, ram_we, arb_busy, ram_addr);
        end
        doc_req = 1'b0;
        @(negedge clk);
        total++;
        if ({doc_gnt, ram_en, doc_rvalid} !== 3'b000) begin
            bad++;
            $display("FAIL doc_wait: got gnt=%b en=%b rvalid=%b want 000", doc_gnt, ram_en, doc_rvalid);
        end
        @(negedge clk);
        total++;
        if (doc_rvalid !== 1'b1) begin
            bad++;
            $display("FAIL doc_latency: rvalid=%b at cycle 3 want 1", doc_rvalid);
        end
        @(negedge clk);
        total++;
        if (doc_rvalid !== 1'b0 || doc_rdata !== 8'h5A) begin
            bad++;
            $display("FAIL doc_hold: rvalid=%b rdata=%h want 0 5a", doc_rvalid, doc_rdata);
        end
    endtask

    task automatic test_host_write();
        host_addr = 16'h00FF; host_wdata = 8'hC3; host_wr = 1'b1; host_req = 1'b1;
        @(negedge clk);
        total++;
        if ({host_gnt, ram_en, ram_we, ram_addr, ram_wdata} !== {3'b111, 16'h00FF, 8'hC3}) begin
            bad++;
            $display("FAIL host_write: got gnt=%b en=%b we=%b addr=%h wdata=%h want 1 1 1 00ff c3",
                     host_gnt, ram_en, ram_we, ram_addr, ram_wdata);
        end
        host_req = 1'b0; host_wr = 1'b0; host_wdata = 8'h00;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (ram_we !== 1'b0 || host_rvalid !== 1'b0) begin
                bad++;
                $display("FAIL host_write_after: we=%b rvalid=%b want 0 0", ram_we, host_rvalid);
            end
        end
        host_q.push_back(8'hC3);
        host_req = 1'b1;
        @(negedge clk);
        total++;
        if ({host_gnt, ram_en, ram_we} !== 3'b110) begin
            bad++;
            $display("FAIL host_read_gnt: gnt=%b en=%b we=%b want 110", host_gnt, ram_en, ram_we);
        end
        host_req = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (host_rvalid !== 1'b1) begin
            bad++;
            $display("FAIL host_read_latency: rvalid=%b want 1", host_rvalid);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [9:0] exp_host;
        int k, last;
        exp_host = 10'b10000_10000;
        k = 0; last = 0;
        doc_addr = 16'h2000; host_addr = 16'h00FF; host_wr = 1'b0;
        doc_req = 1'b1; host_req = 1'b1;
        for (int c = 0; c < 40 && k < 10; c++) begin
            @(negedge clk);
            if (doc_gnt || host_gnt) begin
                total++;
                if (host_gnt !== exp_host[k]) begin
                    bad++;
                    $display("FAIL contention_order: grant %0d host_gnt=%b want %b", k, host_gnt, exp_host[k]);
                end
                if (host_gnt) host_q.push_back(8'hC3);
                else doc_q.push_back(8'h77);
                if (k > 0) begin
                    total++;
                    if (cyc - last != 2) begin
                        bad++;
                        $display("FAIL contention_spacing: grant %0d gap=%0d want 2", k, cyc - last);
                    end
                end
                last = cyc;
                k++;
                if (k == 10) begin doc_req = 1'b0; host_req = 1'b0; end
            end
        end
        doc_req = 1'b0; host_req = 1'b0;
        total++;
        if (k != 10) begin
            bad++;
            $display("FAIL contention_timeout: saw %0d grants want 10", k);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_counter_clear();
        logic [4:0] exp_host;
        int k;
        exp_host = 5'b10000;
        k = 0;
        doc_addr = 16'h2000; host_addr = 16'h00FF; host_wr = 1'b0;
        doc_req = 1'b1; host_req = 1'b1;
        for (int c = 0; c < 20 && k < 2; c++) begin
            @(negedge clk);
            if (doc_gnt || host_gnt) begin
                total++;
                if (doc_gnt !== 1'b1) begin
                    bad++;
                    $display("FAIL clear_pre: grant %0d doc_gnt=%b want 1", k, doc_gnt);
                end
                if (host_gnt) host_q.push_back(8'hC3);
                else doc_q.push_back(8'h77);
                k++;
            end
        end
        host_req = 1'b0;
        @(negedge clk);
        host_req = 1'b1;
        k = 0;
        for (int c = 0; c < 30 && k < 5; c++) begin
            @(negedge clk);
            if (doc_gnt || host_gnt) begin
                total++;
                if (host_gnt !== exp_host[k]) begin
                    bad++;
                    $display("FAIL clear_order: grant %0d host_gnt=%b want %b", k, host_gnt, exp_host[k]);
                end
                if (host_gnt) host_q.push_back(8'hC3);
                else doc_q.push_back(8'h77);
                k++;
                if (k == 5) begin doc_req = 1'b0; host_req = 1'b0; end
            end
        end
        doc_req = 1'b0; host_req = 1'b0;
        total++;
        if (k != 5) begin
            bad++;
            $display("FAIL clear_timeout: saw %0d grants want 5", k);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        doc_addr = 16'h1234; doc_req = 1'b1;
        @(negedge clk);
        total++;
        if (doc_gnt !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_gnt: doc_gnt=%b want 1", doc_gnt);
        end
        doc_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if (all_outs() !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got %h want 0", all_outs());
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (doc_rvalid !== 1'b0 || arb_busy !== 1'b0) begin
                bad++;
                $display("FAIL rst_no_rvalid: rvalid=%b busy=%b want 0 0", doc_rvalid, arb_busy);
            end
        end
        doc_q.push_back(8'h5A);
        doc_req = 1'b1;
        @(negedge clk);
        total++;
        if (doc_gnt !== 1'b1 || ram_addr !== 16'h1234) begin
            bad++;
            $display("FAIL rst_resume: gnt=%b addr=%h want 1 1234", doc_gnt, ram_addr);
        end
        doc_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int k, first;
        k = 0; first = 0;
        host_addr = 16'h00FF; host_wr = 1'b0; host_req = 1'b1;
        for (int c = 0; c < 10 && k < 2; c++) begin
            @(negedge clk);
            if (host_gnt) begin
                host_q.push_back(8'hC3);
                if (k == 0) first = cyc;
                else begin
                    total++;
                    if (cyc - first != 2) begin
                        bad++;
                        $display("FAIL b2b_spacing: gap=%0d want 2", cyc - first);
                    end
                    host_req = 1'b0;
                end
                k++;
            end
        end
        host_req = 1'b0;
        total++;
        if (k != 2) begin
            bad++;
            $display("FAIL b2b_timeout: saw %0d host grants want 2", k);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8);
        mem[16'h1234] = 8'h5A;
        mem[16'h2000] = 8'h77;
        mem[16'h00FF] = 8'h11;
        test_reset();
        test_doc_read();
        test_host_write();
        test_contention();
        test_counter_clear();
        test_reset_mid_read();
        test_back_to_back();
        total++;
        if (doc_q.size() != 0 || host_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: doc left=%0d host left=%0d want 0 0", doc_q.size(), host_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
